c432_irq_sequencer: RTL and testbench

- Clocked front-end that sequences the 27-channel c432 priority interrupt datapath: three groups A, B and C of 9 channels each, gated by a 9-bit per-channel enable E.
- Captures request pulses into sticky pending registers and picks one winner per grant, using fixed group priority A > B > C and, within a group, lowest channel index first.
- Presents the winner to the CPU side over a valid/ack handshake, then retires the serviced pending bit.
- Sits between the raw interrupt sources and the (possibly key-locked) c432 evaluation path; the registered grant gives downstream logic a stable, glitch-free channel code.

---
 rtl/c432_irq_pkg.sv | 37 +++
 rtl/c432_irq_sequencer_if.sv | 26 ++
 rtl/c432_irq_prienc.sv | 36 +++
 rtl/c432_irq_sequencer.sv | 160 ++++++++++++++++
 tb/tb_c432_irq_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/c432_irq_pkg.sv
// Shared constants, group codes, FSM states and channel-index helpers for the
// c432 interrupt sequencer.
package c432_irq_pkg;

    localparam int NCH            = 9;
    localparam int CW             = 4;
    localparam int TIMEOUT_CYCLES = 16;

    localparam logic [1:0] GRP_NONE = 2'b00;
    localparam logic [1:0] GRP_A    = 2'b01;
    localparam logic [1:0] GRP_B    = 2'b10;
    localparam logic [1:0] GRP_C    = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index of the lowest set bit; scanning downwards lets the lowest index overwrite.
    function automatic logic [CW-1:0] lowest_idx(input logic [NCH-1:0] v);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [NCH-1:0] chan_onehot(input logic [CW-1:0] c);
        return {{(NCH-1){1'b0}}, 1'b1} << c;
    endfunction

endpackage

// File: rtl/c432_irq_sequencer_if.sv
// Request/enable/grant bundle between interrupt sources, the sequencer and the CPU.
interface c432_irq_sequencer_if;
    import c432_irq_pkg::*;

    logic [NCH-1:0] req_a;
    logic [NCH-1:0] req_b;
    logic [NCH-1:0] req_c;
    logic [NCH-1:0] en;
    logic           clr_all;
    logic           irq_valid;
    logic [1:0]     irq_group;
    logic [CW-1:0]  irq_chan;
    logic           irq_ack;
    logic           pend_any;
    logic           timeout_flag;

    modport master (
        output req_a, req_b, req_c, en, clr_all, irq_ack,
        input  irq_valid, irq_group, irq_chan, pend_any, timeout_flag
    );

    modport slave (
        input  req_a, req_b, req_c, en, clr_all, irq_ack,
        output irq_valid, irq_group, irq_chan, pend_any, timeout_flag
    );
endinterface

// File: rtl/c432_irq_prienc.sv
// Combinational c432 priority encoder: group A > B > C, lowest channel first.
// Usable standalone as a golden reference against the locked netlist.
module c432_irq_prienc
    import c432_irq_pkg::*;
(
    input  logic [NCH-1:0] elig_a,
    input  logic [NCH-1:0] elig_b,
    input  logic [NCH-1:0] elig_c,
    output logic           found,
    output logic [1:0]     grp,
    output logic [CW-1:0]  chan
);

    // Pick the highest-priority non-empty group, then its lowest eligible channel.
    always_comb begin
        found = 1'b0;
        grp   = GRP_NONE;
        chan  = {CW{1'b0}};
        if (|elig_a) begin
            found = 1'b1;
            grp   = GRP_A;
            chan  = lowest_idx(elig_a);
        end else if (|elig_b) begin
            found = 1'b1;
            grp   = GRP_B;
            chan  = lowest_idx(elig_b);
        end else if (|elig_c) begin
            found = 1'b1;
            grp   = GRP_C;
            chan  = lowest_idx(elig_c);
        end else begin
            found = 1'b0;
        end
    end

endmodule

// File: rtl/c432_irq_sequencer.sv
// Sticky-pending interrupt sequencer with valid/ack grant for the c432 datapath.
// Optional grant withdrawal on missing ack: define C432_IRQ_TIMEOUT_EN.
module c432_irq_sequencer
    import c432_irq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    c432_irq_sequencer_if.slave  bus
);

    state_t         state_r,  state_nxt_s;
    logic [NCH-1:0] pend_a_r, pend_a_nxt_s;
    logic [NCH-1:0] pend_b_r, pend_b_nxt_s;
    logic [NCH-1:0] pend_c_r, pend_c_nxt_s;
    logic           valid_r,  valid_nxt_s;
    logic [1:0]     grp_r,    grp_nxt_s;
    logic [CW-1:0]  chan_r,   chan_nxt_s;
    logic           pany_r,   pany_nxt_s;
`ifdef C432_IRQ_TIMEOUT_EN
    logic [7:0]     cnt_r,    cnt_nxt_s;
    logic           tflag_r,  tflag_nxt_s;
`endif

    logic           found_s;
    logic [1:0]     win_grp_s;
    logic [CW-1:0]  win_chan_s;
    logic           hs_s;
    logic [NCH-1:0] onehot_s;
    logic [NCH-1:0] retire_a_s, retire_b_s, retire_c_s;

    c432_irq_prienc u_prienc (
        .elig_a (pend_a_r & bus.en),
        .elig_b (pend_b_r & bus.en),
        .elig_c (pend_c_r & bus.en),
        .found  (found_s),
        .grp    (win_grp_s),
        .chan   (win_chan_s)
    );

    // valid_r is high exactly while in GRANT, so ack outside a grant is ignored.
    assign hs_s       = valid_r & bus.irq_ack;
    assign onehot_s   = chan_onehot(chan_r);
    assign retire_a_s = (hs_s && grp_r == GRP_A) ? onehot_s : {NCH{1'b0}};
    assign retire_b_s = (hs_s && grp_r == GRP_B) ? onehot_s : {NCH{1'b0}};
    assign retire_c_s = (hs_s && grp_r == GRP_C) ? onehot_s : {NCH{1'b0}};

    // Next-state, pending update and grant outputs; a same-edge request beats retire.
    always_comb begin
        state_nxt_s  = state_r;
        valid_nxt_s  = valid_r;
        grp_nxt_s    = grp_r;
        chan_nxt_s   = chan_r;
        pend_a_nxt_s = (pend_a_r & ~retire_a_s) | bus.req_a;
        pend_b_nxt_s = (pend_b_r & ~retire_b_s) | bus.req_b;
        pend_c_nxt_s = (pend_c_r & ~retire_c_s) | bus.req_c;
`ifdef C432_IRQ_TIMEOUT_EN
        cnt_nxt_s    = cnt_r;
        tflag_nxt_s  = tflag_r;
`endif
        if (bus.clr_all) begin
            state_nxt_s  = IDLE;
            valid_nxt_s  = 1'b0;
            grp_nxt_s    = GRP_NONE;
            chan_nxt_s   = {CW{1'b0}};
            pend_a_nxt_s = {NCH{1'b0}};
            pend_b_nxt_s = {NCH{1'b0}};
            pend_c_nxt_s = {NCH{1'b0}};
`ifdef C432_IRQ_TIMEOUT_EN
            cnt_nxt_s    = 8'd0;
            tflag_nxt_s  = 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_nxt_s = GRANT;
                        valid_nxt_s = 1'b1;
                        grp_nxt_s   = win_grp_s;
                        chan_nxt_s  = win_chan_s;
`ifdef C432_IRQ_TIMEOUT_EN
                        cnt_nxt_s   = 8'd0;
`endif
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                GRANT: begin
                    if (hs_s) begin
                        state_nxt_s = IDLE;
                        valid_nxt_s = 1'b0;
                        grp_nxt_s   = GRP_NONE;
                        chan_nxt_s  = {CW{1'b0}};
`ifdef C432_IRQ_TIMEOUT_EN
                    end else if (cnt_r == 8'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt_s = IDLE;
                        valid_nxt_s = 1'b0;
                        grp_nxt_s   = GRP_NONE;
                        chan_nxt_s  = {CW{1'b0}};
                        tflag_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_r + 8'd1;
`else
                    end else begin
                        state_nxt_s = GRANT;
`endif
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    valid_nxt_s = 1'b0;
                    grp_nxt_s   = GRP_NONE;
                    chan_nxt_s  = {CW{1'b0}};
                end
            endcase
        end
        pany_nxt_s = |((pend_a_nxt_s | pend_b_nxt_s | pend_c_nxt_s) & bus.en);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            pend_a_r <= {NCH{1'b0}};
            pend_b_r <= {NCH{1'b0}};
            pend_c_r <= {NCH{1'b0}};
            valid_r  <= 1'b0;
            grp_r    <= GRP_NONE;
            chan_r   <= {CW{1'b0}};
            pany_r   <= 1'b0;
`ifdef C432_IRQ_TIMEOUT_EN
            cnt_r    <= 8'd0;
            tflag_r  <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            pend_a_r <= pend_a_nxt_s;
            pend_b_r <= pend_b_nxt_s;
            pend_c_r <= pend_c_nxt_s;
            valid_r  <= valid_nxt_s;
            grp_r    <= grp_nxt_s;
            chan_r   <= chan_nxt_s;
            pany_r   <= pany_nxt_s;
`ifdef C432_IRQ_TIMEOUT_EN
            cnt_r    <= cnt_nxt_s;
            tflag_r  <= tflag_nxt_s;
`endif
        end
    end

    assign bus.irq_valid = valid_r;
    assign bus.irq_group = grp_r;
    assign bus.irq_chan  = chan_r;
    assign bus.pend_any  = pany_r;
`ifdef C432_IRQ_TIMEOUT_EN
    assign bus.timeout_flag = tflag_r;
`else
    assign bus.timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_c432_irq_sequencer.sv
// Bench for c432_irq_sequencer: directed vector table, corner sequences and
// randomized traffic against a behavioural model. Honours C432_IRQ_TIMEOUT_EN.
module tb_c432_irq_sequencer;
    import c432_irq_pkg::*;

`ifdef C432_IRQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    c432_irq_sequencer_if bus ();

    c432_irq_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending sets per group, one outstanding grant.
    logic [8:0] m_pend [3];
    bit         m_valid;
    int         m_grp;
    int         m_chan;
    bit         m_pany;
    bit         m_flag;
    int         m_cnt;

    task automatic model_reset();
        for (int g = 0; g < 3; g++) m_pend[g] = 9'h000;
        m_valid = 1'b0; m_grp = 0; m_chan = 0; m_pany = 1'b0; m_flag = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [8:0] ra, input logic [8:0] rb, input logic [8:0] rc,
                              input logic [8:0] e, input logic clr, input logic ack);
        logic [8:0] np [3];
        logic [8:0] rq [3];
        bit         found;
        rq[0] = ra; rq[1] = rb; rq[2] = rc;
        if (clr) begin
            for (int g = 0; g < 3; g++) np[g] = 9'h000;
            m_valid = 1'b0; m_grp = 0; m_chan = 0; m_flag = 1'b0; m_cnt = 0;
        end else begin
            for (int g = 0; g < 3; g++) np[g] = m_pend[g];
            if (m_valid && ack) np[m_grp-1][m_chan] = 1'b0;
            for (int g = 0; g < 3; g++) np[g] = np[g] | rq[g];
            if (m_valid) begin
                if (ack) begin
                    m_valid = 1'b0; m_grp = 0; m_chan = 0;
                end else if (TO_EN && m_cnt == TIMEOUT_CYCLES - 1) begin
                    m_valid = 1'b0; m_grp = 0; m_chan = 0; m_flag = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else begin
                found = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    for (int i = 0; i < 9; i++) begin
                        if (!found && m_pend[g][i] && e[i]) begin
                            found = 1'b1; m_valid = 1'b1; m_grp = g + 1; m_chan = i; m_cnt = 0;
                        end
                    end
                end
            end
        end
        for (int g = 0; g < 3; g++) m_pend[g] = np[g];
        m_pany = |((np[0] | np[1] | np[2]) & e);
    endtask

    // One clock: drive inputs, advance the model at the edge, settle past the edge.
    task automatic cyc(input logic [8:0] ra, input logic [8:0] rb, input logic [8:0] rc,
                       input logic [8:0] e, input logic clr, input logic ack);
        bus.req_a = ra; bus.req_b = rb; bus.req_c = rc;
        bus.en = e; bus.clr_all = clr; bus.irq_ack = ack;
        @(posedge clk);
        model_step(ra, rb, rc, e, clr, ack);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"}, 16'(bus.irq_valid), 16'(m_valid));
        chk({tag, "_group"}, 16'(bus.irq_group), 16'(m_grp));
        if (m_valid) chk({tag, "_chan"}, 16'(bus.irq_chan), 16'(m_chan));
        chk({tag, "_pend_any"}, 16'(bus.pend_any), 16'(m_pany));
        chk({tag, "_tflag"}, 16'(bus.timeout_flag), 16'(m_flag));
    endtask

    typedef struct {
        logic [8:0] ra, rb, rc, en;
        logic       clr, ack;
        logic       v;
        logic [1:0] g;
        logic [3:0] c;
        logic       p;
    } vec_t;

    vec_t tbl [25];

    initial begin
        logic [8:0] ra, rb, rc, e;
        logic       clr, ack;

        //          ra      rb      rc      en      clr   ack   v     g      c     p
        tbl[0]  = '{9'h008, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1};
        tbl[1]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 2'd1, 4'd3, 1'b1};
        tbl[2]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[3]  = '{9'h100, 9'h020, 9'h001, 9'h1FF, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1};
        tbl[4]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 2'd1, 4'd8, 1'b1};
        tbl[5]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1};
        tbl[6]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 2'd2, 4'd5, 1'b1};
        tbl[7]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1};
        tbl[8]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 2'd3, 4'd0, 1'b1};
        tbl[9]  = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[10] = '{9'h000, 9'h004, 9'h000, 9'h1FB, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[11] = '{9'h000, 9'h000, 9'h000, 9'h1FB, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[12] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 2'd2, 4'd2, 1'b1};
        tbl[13] = '{9'h000, 9'h000, 9'h000, 9'h1FB, 1'b0, 1'b0, 1'b1, 2'd2, 4'd2, 1'b0};
        tbl[14] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[15] = '{9'h002, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1};
        tbl[16] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 2'd1, 4'd1, 1'b1};
        tbl[17] = '{9'h002, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1};
        tbl[18] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 1'b1, 2'd1, 4'd1, 1'b1};
        tbl[19] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 2'd1, 4'd1, 1'b1};
        tbl[20] = '{9'h001, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 2'd1, 4'd1, 1'b1};
        tbl[21] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1};
        tbl[22] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 2'd1, 4'd0, 1'b1};
        tbl[23] = '{9'h000, 9'h000, 9'h1FF, 9'h1FF, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
        tbl[24] = '{9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};

        bus.req_a = 9'h000; bus.req_b = 9'h000; bus.req_c = 9'h000;
        bus.en = 9'h1FF; bus.clr_all = 1'b0; bus.irq_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(bus.irq_valid), 16'd0);
        chk("rst_group", 16'(bus.irq_group), 16'd0);
        chk("rst_chan", 16'(bus.irq_chan), 16'd0);
        chk("rst_pend_any", 16'(bus.pend_any), 16'd0);
        chk("rst_tflag", 16'(bus.timeout_flag), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 25; k++) begin
            cyc(tbl[k].ra, tbl[k].rb, tbl[k].rc, tbl[k].en, tbl[k].clr, tbl[k].ack);
            chk($sformatf("tbl%0d_valid", k), 16'(bus.irq_valid), 16'(tbl[k].v));
            chk($sformatf("tbl%0d_group", k), 16'(bus.irq_group), 16'(tbl[k].g));
            if (tbl[k].v) chk($sformatf("tbl%0d_chan", k), 16'(bus.irq_chan), 16'(tbl[k].c));
            chk($sformatf("tbl%0d_pend_any", k), 16'(bus.pend_any), 16'(tbl[k].p));
            chk($sformatf("tbl%0d_tflag", k), 16'(bus.timeout_flag), 16'd0);
        end

        // Asynchronous reset in the middle of a grant on A3.
        cyc(9'h008, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0);
        cyc(9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0);
        chk("mid_grant_valid", 16'(bus.irq_valid), 16'd1);
        chk("mid_grant_chan", 16'(bus.irq_chan), 16'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 16'(bus.irq_valid), 16'd0);
        chk("async_rst_group", 16'(bus.irq_group), 16'd0);
        chk("async_rst_chan", 16'(bus.irq_chan), 16'd0);
        chk("async_rst_pend_any", 16'(bus.pend_any), 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0);
        chk("post_rst_pend_any", 16'(bus.pend_any), 16'd0);
        chk("post_rst_valid", 16'(bus.irq_valid), 16'd0);

`ifdef C432_IRQ_TIMEOUT_EN
        // Grant with no ack is withdrawn after TIMEOUT_CYCLES cycles, then re-granted.
        cyc(9'h010, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0);
        cyc(9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0);
        chk("to_grant_valid", 16'(bus.irq_valid), 16'd1);
        for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
            cyc(9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0);
            chk($sformatf("to_wait%0d_valid", k), 16'(bus.irq_valid), 16'(k < TIMEOUT_CYCLES));
        end
        chk("to_flag_set", 16'(bus.timeout_flag), 16'd1);
        chk("to_pend_kept", 16'(bus.pend_any), 16'd1);
        cyc(9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0);
        chk("to_regrant_valid", 16'(bus.irq_valid), 16'd1);
        chk("to_regrant_chan", 16'(bus.irq_chan), 16'd4);
        chk("to_flag_sticky", 16'(bus.timeout_flag), 16'd1);
        cyc(9'h000, 9'h000, 9'h000, 9'h1FF, 1'b1, 1'b0);
        chk("to_clr_flag", 16'(bus.timeout_flag), 16'd0);
        cyc(9'h000, 9'h000, 9'h000, 9'h1FF, 1'b0, 1'b0);
        chk("to_clr_no_grant", 16'(bus.irq_valid), 16'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ra  = 9'($urandom) & 9'($urandom) & 9'($urandom);
            rb  = 9'($urandom) & 9'($urandom) & 9'($urandom);
            rc  = 9'($urandom) & 9'($urandom) & 9'($urandom);
            e   = ($urandom_range(0, 4) == 0) ? 9'($urandom) : 9'h1FF;
            clr = ($urandom_range(0, 63) == 0);
            ack = ($urandom_range(0, 9) < 4);
            cyc(ra, rb, rc, e, clr, ack);
            chk_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
